// File: rtl/brightness_contrast_pipe.sv
// brightness_contrast_pipe
// ------------------------
// Applies a per-pixel gain (contrast) and a signed offset (brightness) with
// saturation to NUM_CH packed colour channels. It has three pipeline stages:
// S1 multiplies, S2 rounds and adds the offset, S3 saturates. The whole pipe
// holds while datapath_ready is low. New gain/offset values go into staging
// registers first. They become active on the next accepted start-of-frame
// pixel, so one frame never mixes two parameter sets.
//
// Ports:
//   clk, resetN      clock, asynchronous active-low reset
//   en_bp            1 = apply gain/offset, 0 = pass-through (same latency)
//   gain_in          staged gain, unsigned, GAIN_FRAC fractional bits
//   offset_in        staged offset, two's complement, DATA_W+1 bits
//   param_load       strobe: capture gain_in/offset_in into staging
//   sof              start of frame, qualifies the pixel on color_in
//   color_in         NUM_CH*DATA_W pixel, channel 0 in the LSBs
//   color_in_valid   input pixel valid
//   datapath_ready   0 = whole pipe holds
//   color_out        result pixel
//   color_out_valid  result valid
//   param_pending    staged parameters not yet applied
//
// Optional feature, enabled by defining BC_CLIP_STATS_EN:
//   clip_count       number of clipped pixels in the previous frame
//   clip_count_valid one-cycle pulse when clip_count is updated
// Without the macro these ports and the counter logic do not exist.

module brightness_contrast_pipe #(
    parameter int DATA_W    = 8,
    parameter int NUM_CH    = 3,
    parameter int GAIN_W    = 8,
    parameter int GAIN_FRAC = 6
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     en_bp,
    input  logic [GAIN_W-1:0]        gain_in,
    input  logic [DATA_W:0]          offset_in,
    input  logic                     param_load,
    input  logic                     sof,
    input  logic [NUM_CH*DATA_W-1:0] color_in,
    input  logic                     color_in_valid,
    input  logic                     datapath_ready,
    output logic [NUM_CH*DATA_W-1:0] color_out,
    output logic                     color_out_valid,
    output logic                     param_pending
`ifdef BC_CLIP_STATS_EN
    ,
    output logic [15:0]              clip_count,
    output logic                     clip_count_valid
`endif
);

    localparam int PW = DATA_W + GAIN_W;
    localparam int SW = PW + 2;
    localparam int OW = DATA_W + 1;
    localparam logic [GAIN_W-1:0] UNITY_GAIN = GAIN_W'(1 << GAIN_FRAC);
    localparam logic [PW:0]       HALF_LSB   = (PW+1)'(1 << (GAIN_FRAC - 1));
    localparam logic [DATA_W-1:0] MAX_VAL    = '1;

    // Parameter double-buffer state
    logic [GAIN_W-1:0] gainStage_q,   gainStage_d;
    logic [OW-1:0]     offsetStage_q, offsetStage_d;
    logic [GAIN_W-1:0] gainActive_q,  gainActive_d;
    logic [OW-1:0]     offsetActive_q, offsetActive_d;
    logic              pending_q,     pending_d;
    logic              applyNow;
    logic [GAIN_W-1:0] gainUse;
    logic [OW-1:0]     offsetUse;

    // Pipeline state
    logic [NUM_CH-1:0][PW-1:0]  prod1_d;
    logic [NUM_CH-1:0][PW-1:0]  s1Prod_q;
    logic [OW-1:0]              s1Offset_q;
    logic [NUM_CH*DATA_W-1:0]   s1Pix_q;
    logic                       s1Valid_q, s1En_q;

    logic [NUM_CH-1:0][PW:0]    round2;
    logic [NUM_CH-1:0][SW-1:0]  sum2_d;
    logic [NUM_CH-1:0][SW-1:0]  s2Sum_q;
    logic [NUM_CH*DATA_W-1:0]   s2Pix_q;
    logic                       s2Valid_q, s2En_q;

    logic [NUM_CH*DATA_W-1:0]   out3_d;
    logic [NUM_CH*DATA_W-1:0]   colorOut_q;
    logic                       outValid_q;

    // Decide whether this cycle is an apply event. The gain/offset values
    // that a newly accepted pixel carries are chosen here. If param_load
    // coincides with an accepted sof, the values on the inputs bypass the
    // staging registers, so that sof pixel already uses them.
    always_comb begin
        gainStage_d    = param_load ? gain_in   : gainStage_q;
        offsetStage_d  = param_load ? offset_in : offsetStage_q;
        applyNow       = datapath_ready && color_in_valid && sof
                         && (pending_q || param_load);
        gainUse        = applyNow ? gainStage_d   : gainActive_q;
        offsetUse      = applyNow ? offsetStage_d : offsetActive_q;
        gainActive_d   = gainUse;
        offsetActive_d = offsetUse;
        pending_d      = pending_q;
        if (applyNow) begin
            pending_d = 1'b0;
        end else if (param_load) begin
            pending_d = 1'b1;
        end
    end

    // Parameter registers. Staging follows param_load even during a stall.
    // The active set changes only on an accepted sof, which needs ready=1.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            gainStage_q    <= UNITY_GAIN;
            offsetStage_q  <= '0;
            gainActive_q   <= UNITY_GAIN;
            offsetActive_q <= '0;
            pending_q      <= 1'b0;
        end else begin
            gainStage_q    <= gainStage_d;
            offsetStage_q  <= offsetStage_d;
            gainActive_q   <= gainActive_d;
            offsetActive_q <= offsetActive_d;
            pending_q      <= pending_d;
        end
    end

    // S1 datapath: unsigned multiply of each channel by the gain this pixel
    // carries.
    always_comb begin
        prod1_d = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            prod1_d[ch] = PW'(color_in[ch*DATA_W +: DATA_W]) * PW'(gainUse);
        end
    end

    // S1 registers. The offset travels with the pixel, so a later parameter
    // change cannot affect pixels already in flight.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            s1Valid_q  <= 1'b0;
            s1En_q     <= 1'b0;
            s1Prod_q   <= '0;
            s1Offset_q <= '0;
            s1Pix_q    <= '0;
        end else if (datapath_ready) begin
            s1Valid_q  <= color_in_valid;
            s1En_q     <= en_bp;
            s1Prod_q   <= prod1_d;
            s1Offset_q <= offsetUse;
            s1Pix_q    <= color_in;
        end
    end

    // S2 datapath: round half up to an integer, then add the sign-extended
    // offset. The sum has two spare bits, so it cannot overflow. Its MSB is
    // the sign bit.
    always_comb begin
        round2 = '0;
        sum2_d = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            round2[ch] = ({1'b0, s1Prod_q[ch]} + HALF_LSB) >> GAIN_FRAC;
            sum2_d[ch] = {1'b0, round2[ch]}
                       + {{(SW-OW){s1Offset_q[OW-1]}}, s1Offset_q};
        end
    end

    // S2 registers
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            s2Valid_q <= 1'b0;
            s2En_q    <= 1'b0;
            s2Sum_q   <= '0;
            s2Pix_q   <= '0;
        end else if (datapath_ready) begin
            s2Valid_q <= s1Valid_q;
            s2En_q    <= s1En_q;
            s2Sum_q   <= sum2_d;
            s2Pix_q   <= s1Pix_q;
        end
    end

    // S3 datapath: a negative sum clamps to 0. Any set bit above the
    // channel width clamps to full scale. Bypassed pixels take the
    // original input value.
    always_comb begin
        out3_d = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (!s2En_q) begin
                out3_d[ch*DATA_W +: DATA_W] = s2Pix_q[ch*DATA_W +: DATA_W];
            end else if (s2Sum_q[ch][SW-1]) begin
                out3_d[ch*DATA_W +: DATA_W] = '0;
            end else if (|s2Sum_q[ch][SW-2:DATA_W]) begin
                out3_d[ch*DATA_W +: DATA_W] = MAX_VAL;
            end else begin
                out3_d[ch*DATA_W +: DATA_W] = s2Sum_q[ch][DATA_W-1:0];
            end
        end
    end

    // S3 output registers
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            outValid_q <= 1'b0;
            colorOut_q <= '0;
        end else if (datapath_ready) begin
            outValid_q <= s2Valid_q;
            colorOut_q <= out3_d;
        end
    end

    assign color_out       = colorOut_q;
    assign color_out_valid = outValid_q;
    assign param_pending   = pending_q;

`ifdef BC_CLIP_STATS_EN
    logic        s1Sof_q, s2Sof_q, outSof_q, outClip_q;
    logic        clip3_d;
    logic [15:0] clipCnt_q, clipCount_q;
    logic        clipCountValid_q;

    // A pixel counts as clipped if it was processed (not bypassed) and at
    // least one channel hit either rail.
    always_comb begin
        clip3_d = 1'b0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (s2En_q && (s2Sum_q[ch][SW-1] || (|s2Sum_q[ch][SW-2:DATA_W]))) begin
                clip3_d = 1'b1;
            end
        end
    end

    // The sof flag and the clip flag travel alongside the pixel data.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            s1Sof_q   <= 1'b0;
            s2Sof_q   <= 1'b0;
            outSof_q  <= 1'b0;
            outClip_q <= 1'b0;
        end else if (datapath_ready) begin
            s1Sof_q   <= sof && color_in_valid;
            s2Sof_q   <= s1Sof_q;
            outSof_q  <= s2Sof_q;
            outClip_q <= clip3_d;
        end
    end

    // A pixel is counted when it leaves the output register (valid and
    // ready). An sof pixel closes the previous frame: it publishes the
    // count and restarts the counter, including itself if it clipped.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            clipCnt_q        <= '0;
            clipCount_q      <= '0;
            clipCountValid_q <= 1'b0;
        end else begin
            clipCountValid_q <= 1'b0;
            if (outValid_q && datapath_ready) begin
                if (outSof_q) begin
                    clipCount_q      <= clipCnt_q;
                    clipCountValid_q <= 1'b1;
                    clipCnt_q        <= outClip_q ? 16'd1 : 16'd0;
                end else if (outClip_q && (clipCnt_q != 16'hFFFF)) begin
                    clipCnt_q <= clipCnt_q + 16'd1;
                end
            end
        end
    end

    assign clip_count       = clipCount_q;
    assign clip_count_valid = clipCountValid_q;
`endif

endmodule

// File: tb/tb_brightness_contrast_pipe.sv
// Testbench for brightness_contrast_pipe (default parameters: 3 x 8-bit
// channels, gain Q2.6). Expected pixels come from hand-computed constants.
// They are queued in input order. Each time an advancing edge presents a
// valid output, the output is compared against the head of the queue.

module tb_brightness_contrast_pipe;

    logic        clk = 1'b0;
    logic        resetN;
    logic        enBp;
    logic [7:0]  gainIn;
    logic [8:0]  offsetIn;
    logic        paramLoad;
    logic        sof;
    logic [23:0] colorIn;
    logic        colorInValid;
    logic        datapathReady;
    logic [23:0] colorOut;
    logic        colorOutValid;
    logic        paramPending;
`ifdef BC_CLIP_STATS_EN
    logic [15:0] clipCount;
    logic        clipCountValid;
    int          pulses;
    int          consecPulses;
    logic [15:0] lastClip;
    logic        prevPulse;
`endif

    int          checks = 0;
    int          fails  = 0;
    logic        lastAdvance;
    logic [23:0] expQ[$];

    typedef struct packed {
        logic [7:0]  gain;
        logic [8:0]  offset;
        logic        en;
        logic [23:0] pix;
        logic [23:0] exp;
    } vec_t;

    vec_t vecs[8];

    brightness_contrast_pipe dut (
        .clk             (clk),
        .resetN          (resetN),
        .en_bp           (enBp),
        .gain_in         (gainIn),
        .offset_in       (offsetIn),
        .param_load      (paramLoad),
        .sof             (sof),
        .color_in        (colorIn),
        .color_in_valid  (colorInValid),
        .datapath_ready  (datapathReady),
        .color_out       (colorOut),
        .color_out_valid (colorOutValid),
        .param_pending   (paramPending)
`ifdef BC_CLIP_STATS_EN
        ,
        .clip_count      (clipCount),
        .clip_count_valid(clipCountValid)
`endif
    );

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    function automatic logic [23:0] pack3(input logic [7:0] c0, input logic [7:0] c1,
                                          input logic [7:0] c2);
        return {c2, c1, c0};
    endfunction

    function automatic logic [23:0] same3(input logic [7:0] c);
        return {c, c, c};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive every DUT input in one go
    task automatic applyStimulus(input logic [23:0] pix, input logic v, input logic s,
                                 input logic e, input logic pl, input logic [7:0] g,
                                 input logic [8:0] o);
        colorIn      = pix;
        colorInValid = v;
        sof          = s;
        enBp         = e;
        paramLoad    = pl;
        gainIn       = g;
        offsetIn     = o;
    endtask

    task automatic idle();
        applyStimulus(24'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 9'd0);
    endtask

    // One clock edge, then sample 1 time unit later. Only an advancing
    // edge can produce a new output, so only then is the queue head
    // consumed.
    task automatic tick();
        lastAdvance = datapathReady;
        @(posedge clk);
        #1;
        if (lastAdvance && colorOutValid) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected output valid", {31'd0, colorOutValid}, 32'd0);
            end else begin
                checkOutput("stream pixel", {8'd0, colorOut}, {8'd0, expQ.pop_front()});
            end
        end
`ifdef BC_CLIP_STATS_EN
        if (clipCountValid) begin
            pulses++;
            lastClip = clipCount;
            if (prevPulse) consecPulses++;
        end
        prevPulse = clipCountValid;
`endif
    endtask

    task automatic drain(input int n);
        idle();
        for (int i = 0; i < n; i++) tick();
        checkOutput("queue drained", expQ.size(), 0);
    endtask

    initial begin
        // gain, offset, en, pixel in, expected pixel out
        vecs[0] = '{8'd64,  9'd0,    1'b1, pack3(10, 128, 255), pack3(10, 128, 255)};
        vecs[1] = '{8'd96,  9'd10,   1'b1, pack3(100, 1, 200),  pack3(160, 12, 255)};
        vecs[2] = '{8'd32,  9'd0,    1'b1, pack3(1, 2, 3),      pack3(1, 1, 2)};
        vecs[3] = '{8'd128, 9'd0,    1'b1, pack3(200, 100, 0),  pack3(255, 200, 0)};
        vecs[4] = '{8'd64,  9'h1CE,  1'b1, pack3(30, 255, 50),  pack3(0, 205, 0)};
        vecs[5] = '{8'd128, 9'd5,    1'b0, pack3(100, 7, 255),  pack3(100, 7, 255)};
        vecs[6] = '{8'd255, 9'h0FF,  1'b1, pack3(0, 1, 255),    pack3(255, 255, 255)};
        vecs[7] = '{8'd0,   9'd20,   1'b1, pack3(255, 50, 0),   pack3(20, 20, 20)};

`ifdef BC_CLIP_STATS_EN
        pulses       = 0;
        consecPulses = 0;
        lastClip     = 16'd0;
        prevPulse    = 1'b0;
`endif
        datapathReady = 1'b1;
        idle();
        resetN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset color_out", {8'd0, colorOut}, 32'd0);
        checkOutput("reset valid", {31'd0, colorOutValid}, 32'd0);
        checkOutput("reset pending", {31'd0, paramPending}, 32'd0);
        resetN = 1'b1;

        // Table: each vector loads its parameters on its own sof pixel
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].pix, 1'b1, 1'b1, vecs[i].en, 1'b1,
                          vecs[i].gain, vecs[i].offset);
            expQ.push_back(vecs[i].exp);
            tick();
            idle();
            tick();
            tick();
            checkOutput("table valid", {31'd0, colorOutValid}, 32'd1);
            checkOutput("table pending", {31'd0, paramPending}, 32'd0);
            tick();
        end
        checkOutput("table queue", expQ.size(), 0);

        // Identity stream, 3-cycle latency check
        applyStimulus(same3(10), 1'b1, 1'b1, 1'b1, 1'b1, 8'd64, 9'd0);
        expQ.push_back(same3(10));
        tick();
        applyStimulus(same3(128), 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 9'd0);
        expQ.push_back(same3(128));
        tick();
        checkOutput("latency not early", {31'd0, colorOutValid}, 32'd0);
        applyStimulus(same3(255), 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 9'd0);
        expQ.push_back(same3(255));
        tick();
        checkOutput("latency 3 valid", {31'd0, colorOutValid}, 32'd1);
        drain(4);
        checkOutput("valid after drain", {31'd0, colorOutValid}, 32'd0);

        // Mid-frame param load: takes effect only from the next sof
        applyStimulus(24'h0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd128, 9'd0);
        tick();
        checkOutput("pending after load", {31'd0, paramPending}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(same3(50), 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 9'd0);
            expQ.push_back(same3(50));
            tick();
        end
        checkOutput("pending before sof", {31'd0, paramPending}, 32'd1);
        applyStimulus(same3(50), 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 9'd0);
        expQ.push_back(same3(100));
        tick();
        checkOutput("pending cleared on sof", {31'd0, paramPending}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(same3(50), 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 9'd0);
            expQ.push_back(same3(100));
            tick();
        end
        drain(4);

        // param_load coincident with sof applies to that sof pixel
        applyStimulus(same3(50), 1'b1, 1'b1, 1'b1, 1'b1, 8'd64, 9'd0);
        expQ.push_back(same3(50));
        tick();
        checkOutput("coincident pending", {31'd0, paramPending}, 32'd0);
        applyStimulus(same3(50), 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 9'd0);
        expQ.push_back(same3(50));
        tick();
        drain(4);

        // Stall with three pixels in flight
        applyStimulus(same3(10), 1'b1, 1'b1, 1'b1, 1'b1, 8'd128, 9'd0);
        expQ.push_back(same3(20));
        tick();
        applyStimulus(same3(20), 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 9'd0);
        expQ.push_back(same3(20));
        tick();
        applyStimulus(same3(30), 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 9'd0);
        expQ.push_back(same3(60));
        tick();
        datapathReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(same3(8'(i * 37 + 3)), 1'b1, (i == 2), i[0], (i == 1),
                          8'd64, 9'd0);
            tick();
            checkOutput("stall holds data", {8'd0, colorOut}, {8'd0, same3(20)});
            checkOutput("stall holds valid", {31'd0, colorOutValid}, 32'd1);
        end
        checkOutput("load during stall", {31'd0, paramPending}, 32'd1);
        datapathReady = 1'b1;
        drain(4);
        checkOutput("pending kept, no sof", {31'd0, paramPending}, 32'd1);

        // Reset in the middle of a stream discards pixels and parameters
        applyStimulus(same3(40), 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 9'd0);
        tick();
        tick();
        resetN = 1'b0;
        idle();
        tick();
        checkOutput("mid reset valid", {31'd0, colorOutValid}, 32'd0);
        checkOutput("mid reset data", {8'd0, colorOut}, 32'd0);
        checkOutput("mid reset pending", {31'd0, paramPending}, 32'd0);
        resetN = 1'b1;
        applyStimulus(same3(77), 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 9'd0);
        expQ.push_back(same3(77));
        tick();
        applyStimulus(same3(200), 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 9'd0);
        expQ.push_back(same3(200));
        tick();
        drain(4);

        // Bypass toggled per pixel
        for (int i = 0; i < 4; i++) begin
            applyStimulus(same3(100), 1'b1, (i == 0), ~i[0], (i == 0), 8'd128, 9'd0);
            expQ.push_back(i[0] ? same3(100) : same3(200));
            tick();
        end
        drain(4);

`ifdef BC_CLIP_STATS_EN
        // One frame of 10 pixels with 3 clipping, closed by an sof pixel
        resetN = 1'b0;
        idle();
        tick();
        resetN = 1'b1;
        checkOutput("stats reset count", {16'd0, clipCount}, 32'd0);
        pulses       = 0;
        consecPulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 2 || i == 5 || i == 7) begin
                applyStimulus(same3(100), 1'b1, (i == 0), 1'b1, (i == 0), 8'd64, 9'h0C8);
                expQ.push_back(same3(255));
            end else begin
                applyStimulus(same3(10), 1'b1, (i == 0), 1'b1, (i == 0), 8'd64, 9'h0C8);
                expQ.push_back(same3(210));
            end
            tick();
        end
        applyStimulus(same3(10), 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 9'd0);
        expQ.push_back(same3(210));
        tick();
        drain(6);
        checkOutput("clip pulses", pulses, 2);
        checkOutput("clip count", {16'd0, lastClip}, 32'd3);
        checkOutput("clip pulse width", consecPulses, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
